// File: rtl/mdu_sched.sv
// Multi-cycle multiply/divide unit with HI/LO registers and D-stage stall generation.
// The result is computed at the start edge and held in PHI/PLO until the countdown completes.
module mdu_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [4:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_MDUClass,
  output logic        Busy,
  output logic [31:0] Out,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Stall
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MFHI  = 5'd5;
  localparam logic [4:0] OP_MFLO  = 5'd6;
  localparam logic [4:0] OP_MTHI  = 5'd7;
  localparam logic [4:0] OP_MTLO  = 5'd8;

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   phi_q, phi_d, plo_q, plo_d;
  logic          pwr_q, pwr_d;

  logic        is_long;
  logic [63:0] sprod, uprod;
  logic [31:0] a_mag, b_mag, mq, mr, sq, sr, uq, ur;

  assign is_long = (Op == OP_MULT) || (Op == OP_MULTU) || (Op == OP_DIV) || (Op == OP_DIVU);

  // Signed divide works on magnitudes so the most-negative / -1 case stays defined.
  always_comb begin
    sprod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    uprod = {32'd0, A} * {32'd0, B};
    a_mag = A[31] ? (~A + 32'd1) : A;
    b_mag = B[31] ? (~B + 32'd1) : B;
    mq    = '0;
    mr    = '0;
    uq    = '0;
    ur    = '0;
    if (B != 32'd0) begin
      mq = a_mag / b_mag;
      mr = a_mag % b_mag;
      uq = A / B;
      ur = A % B;
    end
    sq = (A[31] ^ B[31]) ? (~mq + 32'd1) : mq;
    sr = A[31] ? (~mr + 32'd1) : mr;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pwr_d   = pwr_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          case (Op)
            OP_MULT: begin
              phi_d   = sprod[63:32];
              plo_d   = sprod[31:0];
              pwr_d   = 1'b1;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_MULTU: begin
              phi_d   = uprod[63:32];
              plo_d   = uprod[31:0];
              pwr_d   = 1'b1;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_DIV: begin
              phi_d   = sr;
              plo_d   = sq;
              pwr_d   = (B != 32'd0);
              cnt_d   = CW'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_DIVU: begin
              phi_d   = ur;
              plo_d   = uq;
              pwr_d   = (B != 32'd0);
              cnt_d   = CW'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Start is ignored here; the stall keeps new MDU ops out of E.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (pwr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      pwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pwr_q   <= pwr_d;
    end
  end

  assign Busy  = (cnt_q != '0);
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign Out   = (Op == OP_MFHI) ? hi_q : (Op == OP_MFLO) ? lo_q : 32'd0;
  assign Stall = D_MDUClass & (Busy | (Start & is_long));

endmodule

// File: tb/tb_mdu_sched.sv
// Randomized + directed bench for mdu_sched against a cycle-level arithmetic reference model.
module tb_mdu_sched;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, Start, D_MDUClass, Busy, Stall;
  logic [4:0]  Op;
  logic [31:0] A, B, Out, HI, LO;

  always #5 clk = ~clk;

  mdu_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .D_MDUClass(D_MDUClass), .Busy(Busy), .Out(Out), .HI(HI), .LO(LO), .Stall(Stall)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: architectural HI/LO, remaining busy cycles and the held result.
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  int          m_busy = 0;
  bit          m_pv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_long(input logic [4:0] op);
    return (op >= 5'd1) && (op <= 5'd4);
  endfunction

  task automatic model_edge();
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(A));
    sb = longint'($signed(B));
    ua = {32'd0, A};
    ub = {32'd0, B};
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 0; m_pv = 1'b0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0 && m_pv) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (Start) begin
      case (Op)
        5'd1: begin p = sa * sb; m_phi = p[63:32]; m_plo = p[31:0]; m_pv = 1'b1; m_busy = MC; end
        5'd2: begin up = ua * ub; m_phi = up[63:32]; m_plo = up[31:0]; m_pv = 1'b1; m_busy = MC; end
        5'd3: begin
          m_pv = (B != 32'd0);
          if (m_pv) begin p = sa / sb; m_plo = p[31:0]; p = sa % sb; m_phi = p[31:0]; end
          m_busy = DC;
        end
        5'd4: begin
          m_pv = (B != 32'd0);
          if (m_pv) begin up = ua / ub; m_plo = up[31:0]; up = ua % ub; m_phi = up[31:0]; end
          m_busy = DC;
        end
        5'd7: m_hi = A;
        5'd8: m_lo = A;
        default: ;
      endcase
    end
  endtask

  // One clock: check every output mid-cycle, then advance model and DUT together.
  task automatic cyc();
    logic [31:0] exp_out;
    @(negedge clk);
    exp_out = (Op == 5'd5) ? m_hi : (Op == 5'd6) ? m_lo : 32'd0;
    chk("busy", {31'd0, Busy}, {31'd0, m_busy != 0});
    chk("stall", {31'd0, Stall}, {31'd0, D_MDUClass & ((m_busy != 0) | (Start & is_long(Op)))});
    chk("out", Out, exp_out);
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    Start = 1'b1; Op = op; A = a; B = b;
    cyc();
    Start = 1'b0; Op = 5'd0;
    n = 0;
    while (Busy && n < 100) begin
      n++;
      cyc();
    end
  endtask

  initial begin
    int n;
    int r;
    reset = 1'b1; Start = 1'b0; Op = 5'd0; A = '0; B = '0; D_MDUClass = 1'b0;
    repeat (2) begin @(posedge clk); model_edge(); end
    #1 reset = 1'b0;
    #1;
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_out", Out, 32'd0);

    run_op(5'd1, 32'hFFFF_FFFD, 32'd4, n);
    chk("mult_cycles", n, MC);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFF4);

    run_op(5'd3, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_cycles", n, DC);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    run_op(5'd4, 32'd7, 32'd2, n);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);

    D_MDUClass = 1'b1;
    Start = 1'b1; Op = 5'd2; A = 32'd3; B = 32'd5;
    #1 chk("stall_start", {31'd0, Stall}, 32'd1);
    cyc();
    Start = 1'b0; Op = 5'd0;
    repeat (MC) begin
      chk("stall_busy", {31'd0, Stall}, 32'd1);
      cyc();
    end
    chk("stall_after", {31'd0, Stall}, 32'd0);
    chk("multu_lo", LO, 32'd15);
    D_MDUClass = 1'b0;
    Start = 1'b1; Op = 5'd2; A = 32'd3; B = 32'd5;
    #1 chk("nostall_start", {31'd0, Stall}, 32'd0);
    Start = 1'b0; Op = 5'd0;
    run_op(5'd2, 32'd3, 32'd5, n);
    chk("multu_cycles", n, MC);

    run_op(5'd7, 32'h1234_5678, 32'd0, n);
    chk("mthi_busy", n, 0);
    chk("mthi_hi", HI, 32'h1234_5678);
    Op = 5'd6;
    #1 chk("mflo_out", Out, 32'd15);
    Op = 5'd5;
    #1 chk("mfhi_out", Out, 32'h1234_5678);
    cyc();
    Op = 5'd0;

    Start = 1'b1; Op = 5'd3; A = 32'd100; B = 32'd7;
    cyc();
    Start = 1'b0; Op = 5'd0;
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    repeat (DC + 2) cyc();
    chk("abort_hi_late", HI, 32'd0);
    chk("abort_lo_late", LO, 32'd0);

    run_op(5'd7, 32'hAAAA_0001, 32'd0, n);
    run_op(5'd8, 32'hBBBB_0002, 32'd0, n);
    run_op(5'd4, 32'd99, 32'd0, n);
    chk("div0_cycles", n, DC);
    chk("div0_hi", HI, 32'hAAAA_0001);
    chk("div0_lo", LO, 32'hBBBB_0002);

    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      D_MDUClass = $urandom_range(0, 1);
      r          = $urandom_range(0, 10);
      Op         = (r == 10) ? 5'd31 : 5'(r);
      r          = $urandom_range(0, 7);
      A          = (r == 0) ? 32'h8000_0000 : $urandom;
      r          = $urandom_range(0, 7);
      B          = (r == 0) ? 32'd0 : (r == 1) ? 32'hFFFF_FFFF :
                   (r == 2) ? 32'($urandom_range(1, 16)) : $urandom;
      Start      = (m_busy == 0) && ($urandom_range(0, 2) != 0);
      cyc();
    end
    reset = 1'b0; Start = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
